reaction_timer: RTL and testbench
=================================

REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 Parameter WAIT_STEP, default 250: wait ticks per unit of random delay, range 1..8191.
REQ-002 Parameter MAX_RT, default 999: reaction-count saturation/timeout value, range 1..1022.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tick  input  1  one-cycle time-base enable (1 ms nominal); all counting occurs only on cycles with tick=1.
REQ-006 start  input  1  one-cycle pulse requesting a new round.
REQ-007 resp  input  1  one-cycle pulse, player response button.
REQ-008 rnd  input  3  pseudo-random value from the upstream 3-bit LFSR; sampled only as defined below.
REQ-009 led  output  1  stimulus lamp; 1 only in state LIT.
REQ-010 busy  output  1  1 in states WAIT and LIT.
REQ-011 result  output  10  last reaction count in ticks; held until the next round completes.
REQ-012 result_valid  output  1  one-cycle pulse when result/early/timeout update.
REQ-013 early  output  1  last round ended by false start.
REQ-014 timeout  output  1  last round ended by MAX_RT saturation.
REQ-015 best  output  10  smallest valid reaction count since reset.

Function
REQ-016 FSM states: IDLE, WAIT, LIT, DONE; only one state active per cycle.
REQ-017 IDLE/DONE with start=1: load wait_cnt = (rnd+1)*WAIT_STEP (16-bit, no overflow for legal parameters), clear rt_cnt to 0, go to WAIT next cycle; early, timeout, result and best are unchanged.
REQ-018 rnd is sampled only on the start-accept cycle; rnd=3'b000 yields WAIT_STEP ticks, 3'b111 yields 8*WAIT_STEP ticks.
REQ-019 WAIT: each tick decrements wait_cnt; the tick that brings wait_cnt from 1 to 0 moves to LIT on the next edge.
REQ-020 WAIT with resp=1: go to DONE, result=0, early=1, timeout=0, result_valid pulse; resp takes priority over a simultaneous final tick.
REQ-021 LIT: led=1; each tick increments rt_cnt.
REQ-022 LIT with resp=1: go to DONE, result=rt_cnt value before any same-cycle increment, early=0, timeout=0, result_valid pulse.
REQ-023 LIT: a tick that would make rt_cnt equal MAX_RT, with resp=0, goes to DONE with result=MAX_RT, timeout=1, early=0, result_valid pulse.
REQ-024 best updates to result only on non-early, non-timeout completion with result < best; equal values leave best unchanged.
REQ-025 start in WAIT or LIT is ignored; resp in IDLE or DONE is ignored.
REQ-026 result_valid is exactly one cycle wide, asserted the cycle after the terminating event (registered), coincident with the DONE entry.
REQ-027 DONE holds all outputs stable; led=0, busy=0.
REQ-028 tick in IDLE or DONE has no effect.

Reset
REQ-029 reset=1 at a clock edge overrides all inputs: state=IDLE, led=0, busy=0, result=0, result_valid=0, early=0, timeout=0, best=10'h3FF, wait_cnt=0, rt_cnt=0.
REQ-030 Reset mid-round (WAIT or LIT) aborts the round without a result_valid pulse; best is also reinitialised.
REQ-031 The first start after reset release is accepted normally.

Verification (bench overrides WAIT_STEP=2, MAX_RT=20, tick every cycle unless stated)
REQ-032 rnd=3'b010, start pulse -> busy=1 next cycle, led rises after exactly 6 ticks, led=0 after resp.
REQ-033 rnd=3'b000, resp 3 ticks after led rises -> result=3, result_valid one cycle, early=0, best=3.
REQ-034 resp during WAIT (including on the final WAIT tick) -> result=0, early=1, led never asserted, best unchanged.
REQ-035 No resp in LIT -> after 20 ticks result=20, timeout=1, DONE; later round with result 5 -> best=5, then result 7 -> best stays 5.
REQ-036 start pulses during WAIT/LIT and resp in IDLE/DONE -> no state or output change; tick held low in WAIT -> led never rises.
REQ-037 reset asserted during LIT -> next cycle led=0, busy=0, result=0, best=1023, no result_valid pulse.

Source files
------------

// File: rtl/reaction_timer_if.sv
// Signal bundle between a reaction-timer core and its surrounding logic:
// time base, player controls, random seed, lamp and round results.
interface reaction_timer_if;
    logic       tick;
    logic       start;
    logic       resp;
    logic [2:0] rnd;
    logic       led;
    logic       busy;
    logic [9:0] result;
    logic       result_valid;
    logic       early;
    logic       timeout;
    logic [9:0] best;

    modport master (
        output tick, start, resp, rnd,
        input  led, busy, result, result_valid, early, timeout, best
    );

    modport slave (
        input  tick, start, resp, rnd,
        output led, busy, result, result_valid, early, timeout, best
    );
endinterface

// File: rtl/reaction_timer.sv
// Reaction timer: random-length wait, then lamp on and reaction counted in ticks.
// Reports early (false start), timeout (saturation at MAX_RT) and best valid time.
module reaction_timer #(
    parameter int WAIT_STEP = 250,
    parameter int MAX_RT    = 999
) (
    input  logic              clk,
    input  logic              reset,
    reaction_timer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, WAIT, LIT, DONE} state_t;

    localparam logic [15:0] STEP = 16'(WAIT_STEP);
    localparam logic [9:0]  MAX  = 10'(MAX_RT);

    state_t      state;
    logic [15:0] wait_cnt;
    logic [9:0]  rt_cnt;
    logic        led_q;
    logic        busy_q;
    logic [9:0]  result_q;
    logic        result_valid_q;
    logic        early_q;
    logic        timeout_q;
    logic [9:0]  best_q;

    logic [15:0] wait_load;
    logic [9:0]  rt_next;

    assign wait_load = ({13'd0, bus.rnd} + 16'd1) * STEP;
    assign rt_next   = rt_cnt + 10'd1;

    // NOTE: all state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            rt_cnt         <= '0;
            led_q          <= 1'b0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            early_q        <= 1'b0;
            timeout_q      <= 1'b0;
            best_q         <= 10'h3FF;
        end else begin
            result_valid_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        wait_cnt <= wait_load;
                        rt_cnt   <= '0;
                        state    <= WAIT;
                        busy_q   <= 1'b1;
                        led_q    <= 1'b0;
                    end
                end
                WAIT: begin
                    // A press during the wait wins over the final wait tick.
                    if (bus.resp) begin
                        state          <= DONE;
                        busy_q         <= 1'b0;
                        result_q       <= '0;
                        early_q        <= 1'b1;
                        timeout_q      <= 1'b0;
                        result_valid_q <= 1'b1;
                    end else if (bus.tick) begin
                        if (wait_cnt <= 16'd1) begin
                            wait_cnt <= '0;
                            state    <= LIT;
                            led_q    <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt - 16'd1;
                        end
                    end
                end
                LIT: begin
                    if (bus.resp) begin
                        state          <= DONE;
                        led_q          <= 1'b0;
                        busy_q         <= 1'b0;
                        result_q       <= rt_cnt;
                        early_q        <= 1'b0;
                        timeout_q      <= 1'b0;
                        result_valid_q <= 1'b1;
                        if (rt_cnt < best_q) begin
                            best_q <= rt_cnt;
                        end
                    end else if (bus.tick) begin
                        rt_cnt <= rt_next;
                        if (rt_next == MAX) begin
                            state          <= DONE;
                            led_q          <= 1'b0;
                            busy_q         <= 1'b0;
                            result_q       <= MAX;
                            early_q        <= 1'b0;
                            timeout_q      <= 1'b1;
                            result_valid_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.led          = led_q;
    assign bus.busy         = busy_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.early        = early_q;
    assign bus.timeout      = timeout_q;
    assign bus.best         = best_q;
endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer with WAIT_STEP=2, MAX_RT=20; inputs change
// 1 time unit after each rising edge and outputs are checked at the same point.
module tb_reaction_timer;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    reaction_timer_if bus ();

    reaction_timer #(.WAIT_STEP(2), .MAX_RT(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [2:0] r);
        bus.rnd   = r;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic pulse_resp();
        bus.resp = 1'b1;
        step(1);
        bus.resp = 1'b0;
    endtask

    task automatic check_done(input string tag, input logic [9:0] res, input logic e,
                              input logic t, input logic [9:0] b);
        check({tag, "_led"}, 16'(bus.led), 16'd0);
        check({tag, "_busy"}, 16'(bus.busy), 16'd0);
        check({tag, "_result"}, 16'(bus.result), 16'(res));
        check({tag, "_valid"}, 16'(bus.result_valid), 16'd1);
        check({tag, "_early"}, 16'(bus.early), 16'(e));
        check({tag, "_timeout"}, 16'(bus.timeout), 16'(t));
        check({tag, "_best"}, 16'(bus.best), 16'(b));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.tick = 1'b1;
        bus.start = 1'b0;
        bus.resp = 1'b0;
        bus.rnd = 3'd0;
        step(2);
        check("rst_led", 16'(bus.led), 16'd0);
        check("rst_busy", 16'(bus.busy), 16'd0);
        check("rst_result", 16'(bus.result), 16'd0);
        check("rst_valid", 16'(bus.result_valid), 16'd0);
        check("rst_early", 16'(bus.early), 16'd0);
        check("rst_timeout", 16'(bus.timeout), 16'd0);
        check("rst_best", 16'(bus.best), 16'h3FF);
        reset = 1'b0;
        step(1);

        // rnd=2: 6 wait ticks, then 4 LIT ticks before the press.
        pulse_start(3'd2);
        check("a_busy", 16'(bus.busy), 16'd1);
        check("a_led0", 16'(bus.led), 16'd0);
        step(5);
        check("a_led_t5", 16'(bus.led), 16'd0);
        step(1);
        check("a_led_t6", 16'(bus.led), 16'd1);
        step(4);
        pulse_resp();
        check_done("a", 10'd4, 1'b0, 1'b0, 10'd4);
        step(1);
        check("a_valid_off", 16'(bus.result_valid), 16'd0);
        check("a_hold", 16'(bus.result), 16'd4);

        // rnd=0: 2 wait ticks, press on the 4th LIT cycle -> 3.
        pulse_start(3'd0);
        step(1);
        check("b_led_t1", 16'(bus.led), 16'd0);
        step(1);
        check("b_led_t2", 16'(bus.led), 16'd1);
        step(3);
        pulse_resp();
        check_done("b", 10'd3, 1'b0, 1'b0, 10'd3);
        step(1);
        check("b_valid_off", 16'(bus.result_valid), 16'd0);

        // Press on the final wait tick: early wins, lamp never lit.
        pulse_start(3'd0);
        step(1);
        check("c_led", 16'(bus.led), 16'd0);
        pulse_resp();
        check_done("c", 10'd0, 1'b1, 1'b0, 10'd3);

        // Ignored inputs: resp in DONE, start in WAIT, tick held low in WAIT.
        pulse_resp();
        check("d_resp_valid", 16'(bus.result_valid), 16'd0);
        check("d_resp_early", 16'(bus.early), 16'd1);
        check("d_resp_busy", 16'(bus.busy), 16'd0);
        bus.tick = 1'b0;
        pulse_start(3'd1);
        step(8);
        check("d_notick_led", 16'(bus.led), 16'd0);
        check("d_notick_busy", 16'(bus.busy), 16'd1);
        pulse_start(3'd7);
        check("d_start_wait", 16'(bus.led), 16'd0);
        bus.tick = 1'b1;
        step(3);
        check("d_led_t3", 16'(bus.led), 16'd0);
        step(1);
        check("d_led_t4", 16'(bus.led), 16'd1);
        pulse_start(3'd5);
        check("d_start_lit_led", 16'(bus.led), 16'd1);
        check("d_start_lit_valid", 16'(bus.result_valid), 16'd0);
        step(1);
        pulse_resp();
        check_done("d", 10'd2, 1'b0, 1'b0, 10'd2);

        // No press: saturate at MAX_RT.
        pulse_start(3'd0);
        step(2);
        check("e_led", 16'(bus.led), 16'd1);
        step(19);
        check("e_led_t19", 16'(bus.led), 16'd1);
        check("e_valid_t19", 16'(bus.result_valid), 16'd0);
        step(1);
        check_done("e", 10'd20, 1'b0, 1'b1, 10'd2);

        // Reset in LIT aborts the round and reinitialises best.
        pulse_start(3'd0);
        step(4);
        check("f_led", 16'(bus.led), 16'd1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("f_led_off", 16'(bus.led), 16'd0);
        check("f_busy", 16'(bus.busy), 16'd0);
        check("f_result", 16'(bus.result), 16'd0);
        check("f_best", 16'(bus.best), 16'h3FF);
        check("f_timeout", 16'(bus.timeout), 16'd0);
        step(1);
        check("f_valid", 16'(bus.result_valid), 16'd0);

        // Best tracking after reset: 5 then 7 leaves best at 5.
        pulse_start(3'd0);
        step(2);
        check("g_led", 16'(bus.led), 16'd1);
        step(5);
        pulse_resp();
        check_done("g5", 10'd5, 1'b0, 1'b0, 10'd5);
        pulse_start(3'd0);
        step(9);
        pulse_resp();
        check_done("g7", 10'd7, 1'b0, 1'b0, 10'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
